// File: rtl/alpha_blender.sv
// Per-pixel alpha compositing stage: latches one RGBA source pixel, reads the
// destination RGB back from the frame buffer, then writes the blended colour.
module alpha_blender #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        finished,
    input  logic [16:0] pixel_number,
    input  logic        pixel_ready,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic [7:0]  a,
    input  logic [7:0]  read_r,
    input  logic [7:0]  read_g,
    input  logic [7:0]  read_b,
    input  logic        frame_ready,
    output logic        o_frame_ready,
    output logic        read,
    output logic        write,
    output logic [7:0]  write_r,
    output logic [7:0]  write_g,
    output logic [7:0]  write_b,
    output logic [16:0] pixel_number_o,
    output logic        finished_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    localparam logic [3:0] LP_CNT_LOAD = 4'(READ_LATENCY - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_src_r;
    logic [7:0]  r_src_g;
    logic [7:0]  r_src_b;
    logic [7:0]  r_src_a;
    logic [16:0] r_pixel_number;
    logic        r_frame_ready;
    logic        r_finished;

    logic [1:0]  w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_accept;
    logic        w_finished_nxt;

    // Exact floor(x / 255) for x <= 65025 via (x + (x >> 8) + 1) >> 8.
    function automatic logic [7:0] blend_channel(
        input logic [7:0] src,
        input logic [7:0] dst,
        input logic [7:0] alpha
    );
        logic [15:0] sum;
        logic [15:0] adj;
        sum = 16'(alpha) * 16'(src) + 16'(8'd255 - alpha) * 16'(dst);
        adj = sum + {8'd0, sum[15:8]} + 16'd1;
        return 8'(adj >> 8);
    endfunction

    // A new pixel is taken only from IDLE or from WRITE; during READ it is dropped.
    assign w_accept = pixel_ready && ((r_state == ST_IDLE) || (r_state == ST_WRITE));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (pixel_ready) begin
                    w_state_nxt = ST_READ;
                    w_cnt_nxt   = LP_CNT_LOAD;
                end
            end
            ST_READ: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_WRITE: begin
                if (pixel_ready) begin
                    w_state_nxt = ST_READ;
                    w_cnt_nxt   = LP_CNT_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_finished_nxt = r_finished;
        if (!finished) begin
            w_finished_nxt = 1'b0;
        end else if ((r_state == ST_IDLE) && !pixel_ready) begin
            w_finished_nxt = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 4'd0;
            r_src_r        <= 8'd0;
            r_src_g        <= 8'd0;
            r_src_b        <= 8'd0;
            r_src_a        <= 8'd0;
            r_pixel_number <= 17'd0;
            r_frame_ready  <= 1'b0;
            r_finished     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_frame_ready <= frame_ready;
            r_finished    <= w_finished_nxt;
            if (w_accept) begin
                r_src_r        <= r;
                r_src_g        <= g;
                r_src_b        <= b;
                r_src_a        <= a;
                r_pixel_number <= pixel_number;
            end
        end
    end

    assign read           = (r_state == ST_READ);
    assign write          = (r_state == ST_WRITE);
    assign pixel_number_o = r_pixel_number;
    assign o_frame_ready  = r_frame_ready;
    assign finished_o     = r_finished;

    // Destination data is live; the frame buffer holds it stable through the write cycle.
    assign write_r = blend_channel(r_src_r, read_r, r_src_a);
    assign write_g = blend_channel(r_src_g, read_g, r_src_a);
    assign write_b = blend_channel(r_src_b, read_b, r_src_a);

endmodule

// File: tb/tb_alpha_blender.sv
// Bench for alpha_blender: timeline model checked every cycle plus directed
// vectors with hand-computed expectations.
module tb_alpha_blender;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        finished;
    logic [16:0] pixel_number;
    logic        pixel_ready;
    logic [7:0]  r, g, b, a;
    logic [7:0]  read_r, read_g, read_b;
    logic        frame_ready;
    logic        o_frame_ready;
    logic        read;
    logic        write;
    logic [7:0]  write_r, write_g, write_b;
    logic [16:0] pixel_number_o;
    logic        finished_o;

    always #5 clk = ~clk;

    alpha_blender #(.READ_LATENCY(L)) dut (
        .clk            (clk),
        .reset          (reset),
        .finished       (finished),
        .pixel_number   (pixel_number),
        .pixel_ready    (pixel_ready),
        .r              (r),
        .g              (g),
        .b              (b),
        .a              (a),
        .read_r         (read_r),
        .read_g         (read_g),
        .read_b         (read_b),
        .frame_ready    (frame_ready),
        .o_frame_ready  (o_frame_ready),
        .read           (read),
        .write          (write),
        .write_r        (write_r),
        .write_g        (write_g),
        .write_b        (write_b),
        .pixel_number_o (pixel_number_o),
        .finished_o     (finished_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int ref_blend(input int c, input int d, input int al);
        return (al * c + (255 - al) * d) / 255;
    endfunction

    // Model: m_k counts edges since the last accepted pixel (0 = idle).
    // Read spans m_k = 1..L, write is m_k = L+1.
    int          m_k   = 0;
    bit          m_on  = 1'b0;
    int          m_r, m_g, m_b, m_a;
    int          m_pn;
    bit          m_fr, m_fin;

    always @(posedge clk) begin
        if (!reset) begin
            m_on = 1'b1;
            m_k  = 0;
            m_r  = 0; m_g = 0; m_b = 0; m_a = 0; m_pn = 0;
            m_fr = 1'b0; m_fin = 1'b0;
        end else begin
            m_fr = frame_ready;
            if (!finished) m_fin = 1'b0;
            else if (m_k == 0 && !pixel_ready) m_fin = 1'b1;
            if (pixel_ready && (m_k == 0 || m_k == L + 1)) begin
                m_r = int'(r); m_g = int'(g); m_b = int'(b); m_a = int'(a);
                m_pn = int'(pixel_number);
                m_k = 1;
            end else if (m_k == L + 1) begin
                m_k = 0;
            end else if (m_k > 0) begin
                m_k++;
            end
        end
        #1;
        if (m_on) begin
            check("m_read",  32'(read),  32'(m_k >= 1 && m_k <= L));
            check("m_write", 32'(write), 32'(m_k == L + 1));
            check("m_pnum",  32'(pixel_number_o), 32'(m_pn));
            check("m_wr_r",  32'(write_r), 32'(ref_blend(m_r, int'(read_r), m_a)));
            check("m_wr_g",  32'(write_g), 32'(ref_blend(m_g, int'(read_g), m_a)));
            check("m_wr_b",  32'(write_b), 32'(ref_blend(m_b, int'(read_b), m_a)));
            check("m_frame", 32'(o_frame_ready), 32'(m_fr));
            check("m_fin",   32'(finished_o), 32'(m_fin));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_src(input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb,
                           input logic [7:0] ca, input logic [16:0] pn);
        r = cr; g = cg; b = cb; a = ca; pixel_number = pn;
    endtask

    task automatic set_dst(input logic [7:0] dr, input logic [7:0] dg, input logic [7:0] db);
        read_r = dr; read_g = dg; read_b = db;
    endtask

    // Pulse pixel_ready for one accept edge, then scramble the source inputs.
    task automatic issue_pixel;
        pixel_ready = 1'b1;
        edges(1);
        pixel_ready = 1'b0;
        set_src(8'hA5, 8'h5A, 8'h3C, 8'h81, 17'h1FFFF);
    endtask

    typedef struct {
        logic [7:0] c, d, al;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'd255, 8'd0,   8'd1};
        vecs[1] = '{8'd0,   8'd255, 8'd254};
        vecs[2] = '{8'd200, 8'd100, 8'd128};
        vecs[3] = '{8'd255, 8'd255, 8'd77};
        vecs[4] = '{8'd13,  8'd240, 8'd255};
        vecs[5] = '{8'd99,  8'd7,   8'd0};

        reset = 1'b0; finished = 1'b0; pixel_ready = 1'b0; frame_ready = 1'b0;
        set_src(8'd0, 8'd0, 8'd0, 8'd0, 17'd0);
        set_dst(8'd77, 8'd0, 8'd0);
        edges(2);
        check("rst_read",   32'(read), 32'd0);
        check("rst_write",  32'(write), 32'd0);
        check("rst_pnum",   32'(pixel_number_o), 32'd0);
        check("rst_frame",  32'(o_frame_ready), 32'd0);
        check("rst_fin",    32'(finished_o), 32'd0);
        check("rst_wr_r",   32'(write_r), 32'd77);
        reset = 1'b1;
        edges(1);

        // Partial alpha, with handshake timing against pixel 5.
        set_dst(8'd1, 8'd2, 8'd3);
        set_src(8'd128, 8'd64, 8'd192, 8'd17, 17'd5);
        issue_pixel();
        check("hs_pnum_n",  32'(pixel_number_o), 32'd5);
        check("hs_read_n",  32'(read), 32'd1);
        check("hs_write_n", 32'(write), 32'd0);
        edges(1);
        check("hs_read_n1", 32'(read), 32'd1);
        check("hs_wr_n1",   32'(write), 32'd0);
        edges(1);
        check("hs_read_n2", 32'(read), 32'd0);
        check("hs_write_n2", 32'(write), 32'd1);
        check("part_r", 32'(write_r), 32'd9);
        check("part_g", 32'(write_g), 32'd6);
        check("part_b", 32'(write_b), 32'd15);
        edges(1);
        check("hs_write_n3", 32'(write), 32'd0);
        check("hold_r", 32'(write_r), 32'd9);

        // Transparent source.
        set_dst(8'd255, 8'd170, 8'd0);
        set_src(8'd0, 8'd0, 8'd0, 8'd0, 17'd6);
        issue_pixel();
        edges(2);
        check("transp_r", 32'(write_r), 32'd255);
        check("transp_g", 32'(write_g), 32'd170);
        check("transp_b", 32'(write_b), 32'd0);
        edges(1);

        // Opaque source.
        set_src(8'd0, 8'd0, 8'd0, 8'd255, 17'd7);
        issue_pixel();
        edges(2);
        check("opaque_r", 32'(write_r), 32'd0);
        check("opaque_g", 32'(write_g), 32'd0);
        check("opaque_b", 32'(write_b), 32'd0);
        edges(1);

        // Back-to-back: pixel_ready held; the pixel shown during READ is dropped.
        set_dst(8'd10, 8'd20, 8'd30);
        set_src(8'd50, 8'd60, 8'd70, 8'd100, 17'd5);
        pixel_ready = 1'b1;
        edges(1);
        set_src(8'd250, 8'd240, 8'd230, 8'd200, 17'd9);
        edges(2);
        check("b2b_write",  32'(write), 32'd1);
        check("b2b_pnum_w", 32'(pixel_number_o), 32'd5);
        edges(1);
        pixel_ready = 1'b0;
        check("b2b_pnum",   32'(pixel_number_o), 32'd9);
        check("b2b_read",   32'(read), 32'd1);
        edges(3);

        // Model sweep over alpha extremes and mid values.
        for (int i = 0; i < 6; i++) begin
            set_dst(vecs[i].d, 8'(vecs[i].d + 8'd3), 8'(255 - vecs[i].d));
            set_src(vecs[i].c, 8'(255 - vecs[i].c), 8'(vecs[i].c ^ 8'h55), vecs[i].al, 17'(100 + i));
            issue_pixel();
            edges(3);
        end

        // Status forwarding.
        frame_ready = 1'b1;
        edges(1);
        frame_ready = 1'b0;
        check("frame_fwd", 32'(o_frame_ready), 32'd1);
        edges(1);
        check("frame_clr", 32'(o_frame_ready), 32'd0);
        finished = 1'b1;
        edges(1);
        check("fin_idle", 32'(finished_o), 32'd1);
        finished = 1'b0;
        edges(1);
        check("fin_clr", 32'(finished_o), 32'd0);

        // finished raised with a pixel: held off until the FSM is idle again.
        finished = 1'b1;
        set_src(8'd1, 8'd1, 8'd1, 8'd1, 17'd11);
        issue_pixel();
        check("fin_busy_n",  32'(finished_o), 32'd0);
        edges(2);
        check("fin_busy_w",  32'(finished_o), 32'd0);
        edges(1);
        check("fin_busy_i",  32'(finished_o), 32'd0);
        edges(1);
        check("fin_after",   32'(finished_o), 32'd1);
        finished = 1'b0;
        edges(1);

        // Reset mid-operation aborts the pixel; the first edge after release accepts.
        set_src(8'd9, 8'd9, 8'd9, 8'd9, 17'd21);
        issue_pixel();
        reset = 1'b0;
        edges(1);
        check("mid_rst_read",  32'(read), 32'd0);
        check("mid_rst_write", 32'(write), 32'd0);
        check("mid_rst_pnum",  32'(pixel_number_o), 32'd0);
        reset = 1'b1;
        set_src(8'd40, 8'd40, 8'd40, 8'd40, 17'd33);
        issue_pixel();
        check("post_rst_pnum", 32'(pixel_number_o), 32'd33);
        check("post_rst_read", 32'(read), 32'd1);
        edges(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
